// File: rtl/usr_ctrl.sv
// rtl/usr_ctrl.sv - 2-entry word FIFO feeding a load/shift sequencer for a 4-bit universal shift register
// Optional: define USR_CTRL_AUTOCHAIN_EN to let DONE chain straight into the next LOAD.
module usr_ctrl #(
   parameter int SHIFT_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_dir,
   input  logic       ser_in,
   output logic [1:0] usr_mode,
   output logic [3:0] usr_inp,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   localparam logic [2:0] LP_LAST = 3'(SHIFT_LEN - 1);

   state_t     r_state;
   logic [3:0] r_fifo_data [2];
   logic       r_fifo_dir  [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic [2:0] r_shift_cnt;
   logic       r_dir;

   logic       w_push;
   logic       w_pop;
   logic       w_avail;

   // Readiness depends only on stored occupancy, so a full FIFO never takes a word even while popping.
   assign in_ready = (r_count != 2'd2) && !rst;
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_state == S_LOAD);
   assign w_avail  = (r_count != 2'd0) || w_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= 4'b0000;
            r_fifo_dir[i]  <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= in_data;
            r_fifo_dir[r_wr_ptr]  <= in_dir;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift_cnt <= 3'd0;
         r_dir       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_avail) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_dir       <= r_fifo_dir[r_rd_ptr];
               r_shift_cnt <= 3'd0;
               r_state     <= S_SHIFT;
            end
            S_SHIFT: begin
               r_shift_cnt <= r_shift_cnt + 3'd1;
               if (r_shift_cnt == LP_LAST) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
`ifdef USR_CTRL_AUTOCHAIN_EN
               r_state <= w_avail ? S_LOAD : S_IDLE;
`else
               r_state <= S_IDLE;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Downstream command bus decodes registered state only; no path from the upstream handshake.
   always_comb begin
      usr_mode = 2'b00;
      usr_inp  = 4'b0000;
      done     = 1'b0;
      case (r_state)
         S_LOAD: begin
            usr_mode = 2'b11;
            usr_inp  = r_fifo_data[r_rd_ptr];
         end
         S_SHIFT: begin
            usr_mode = r_dir ? 2'b10 : 2'b01;
            usr_inp  = {3'b000, ser_in};
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            usr_mode = 2'b00;
         end
      endcase
   end

   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_usr_ctrl.sv
// tb/tb_usr_ctrl.sv - scoreboard bench for usr_ctrl (SHIFT_LEN=4 and SHIFT_LEN=1 instances)
`timescale 1ns/1ps
module tb_usr_ctrl;
`ifdef USR_CTRL_AUTOCHAIN_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 2;
`endif
   localparam int NDUT = 2;

   typedef struct {
      int         d;
      logic [3:0] data;
      logic       dir;
      logic       s;
      int         acc;
   } word_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid [NDUT];
   logic       in_ready [NDUT];
   logic [3:0] in_data  [NDUT];
   logic       in_dir   [NDUT];
   logic       ser_in   [NDUT];
   logic [1:0] usr_mode [NDUT];
   logic [3:0] usr_inp  [NDUT];
   logic       busy     [NDUT];
   logic       done     [NDUT];

   word_t      sb [$];
   int         n_cmp;
   int         n_bad;
   int         cyc;
   int         rst_seen;
   logic       in_frame  [NDUT];
   int         load_cyc  [NDUT];
   int         last_done [NDUT];
   int         prev_load [NDUT];
   int         last_load [NDUT];
   int         done_cnt  [NDUT];
   int         busy_cnt  [NDUT];
   word_t      cur       [NDUT];
   logic [3:0] mir       [NDUT];

   always #5 clk = ~clk;

   usr_ctrl #(.SHIFT_LEN(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_dir(in_dir[0]), .ser_in(ser_in[0]),
      .usr_mode(usr_mode[0]), .usr_inp(usr_inp[0]), .busy(busy[0]), .done(done[0])
   );

   usr_ctrl #(.SHIFT_LEN(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_dir(in_dir[1]), .ser_in(ser_in[1]),
      .usr_mode(usr_mode[1]), .usr_inp(usr_inp[1]), .busy(busy[1]), .done(done[1])
   );

   function automatic int len_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   // Contents of the downstream register after loading data and shifting n times with constant fill s.
   function automatic logic [3:0] final_val(input logic [3:0] data, input logic dir, input logic s, input int n);
      logic [10:0] t;
      if (!dir) begin
         t = {{7{s}}, data};
         t = t >> n;
      end else begin
         t = {data, {7{s}}};
         t = t >> (7 - n);
      end
      return t[3:0];
   endfunction

   function automatic int pending(input int d);
      int n = 0;
      foreach (sb[i]) if (sb[i].d == d) n++;
      return n;
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
      end
   endtask

   task automatic mon(input int d);
      logic [1:0] e_mode;
      logic [3:0] e_inp;
      logic       e_done;
      logic       e_busy;
      logic       e_rdy;
      int         idx;
      int         occ;
      int         off;
      int         due;
      word_t      w;
      e_mode = 2'b00;
      e_inp  = 4'b0000;
      e_done = 1'b0;
      e_busy = 1'b0;
      idx    = -1;
      foreach (sb[i]) if (sb[i].d == d && idx < 0) idx = i;
      if (!in_frame[d] && idx >= 0) begin
         due = sb[idx].acc + 1;
         if (last_done[d] + GAP > due) due = last_done[d] + GAP;
         if (cyc == due) begin
            cur[d]       = sb[idx];
            sb.delete(idx);
            in_frame[d]  = 1'b1;
            load_cyc[d]  = cyc;
            prev_load[d] = last_load[d];
            last_load[d] = cyc;
         end
      end
      occ = pending(d);
      if (in_frame[d]) begin
         off    = cyc - load_cyc[d];
         e_busy = 1'b1;
         if (off == 0) begin
            e_mode = 2'b11;
            e_inp  = cur[d].data;
            occ++;
         end else if (off <= len_of(d)) begin
            e_mode = cur[d].dir ? 2'b10 : 2'b01;
            e_inp  = {3'b000, ser_in[d]};
         end else begin
            e_done = 1'b1;
         end
      end
      e_rdy = !rst && (occ < 2);
      check("mode_inp_done_busy_ready", d,
            {23'd0, usr_mode[d], usr_inp[d], done[d], busy[d], in_ready[d]},
            {23'd0, e_mode, e_inp, e_done, e_busy, e_rdy});
      if (in_frame[d] && e_done) begin
         w = cur[d];
         check("mirror_final", d, {28'd0, mir[d]}, {28'd0, final_val(w.data, w.dir, w.s, len_of(d))});
         in_frame[d]  = 1'b0;
         last_done[d] = cyc;
      end
      if (done[d] === 1'b1) done_cnt[d]++;
      if (busy[d] === 1'b1) busy_cnt[d]++;
      case (usr_mode[d])
         2'b11:   mir[d] = usr_inp[d];
         2'b01:   mir[d] = {usr_inp[d][0], mir[d][3:1]};
         2'b10:   mir[d] = {mir[d][2:0], usr_inp[d][0]};
         default: mir[d] = mir[d];
      endcase
      if (in_valid[d] && in_ready[d]) begin
         w.d = d; w.data = in_data[d]; w.dir = in_dir[d]; w.s = ser_in[d]; w.acc = cyc;
         sb.push_back(w);
      end
      if (rst) begin
         for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
         in_frame[d]  = 1'b0;
         last_done[d] = -100;
      end
   endtask

   initial begin
      rst_seen = 0;
      cyc      = 0;
      for (int d = 0; d < NDUT; d++) begin
         in_frame[d] = 1'b0; last_done[d] = -100; mir[d] = 4'b0000;
         prev_load[d] = 0; last_load[d] = 0; done_cnt[d] = 0; busy_cnt[d] = 0; load_cyc[d] = 0;
      end
      forever begin
         @(negedge clk);
         if (rst) rst_seen++;
         if (rst_seen >= 2) begin
            for (int d = 0; d < NDUT; d++) mon(d);
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input logic [3:0] data, input logic dir);
      int ok = 0;
      in_data[d]  = data;
      in_dir[d]   = dir;
      in_valid[d] = 1'b1;
      for (int t = 0; t < 200 && ok == 0; t++) begin
         @(negedge clk);
         if (in_ready[d]) ok = 1;
         step();
      end
      check("accept_wait", d, ok, 1);
   endtask

   task automatic drain(input int d);
      int quiet = 0;
      in_valid[d] = 1'b0;
      for (int t = 0; t < 400 && quiet < 3; t++) begin
         @(negedge clk);
         #1;
         if (!busy[d] && pending(d) == 0 && !in_frame[d]) quiet++;
         else quiet = 0;
      end
      check("drain_wait", d, quiet, 3);
      step();
   endtask

   task automatic random_run(input int d, input int nwords);
      ser_in[d] = 1'($urandom_range(0, 1));
      for (int k = 0; k < nwords; k++) begin
         int gap = $urandom_range(0, 3);
         if (gap > 0) begin
            in_valid[d] = 1'b0;
            repeat (gap) step();
         end
         send(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (k % 10 == 9) begin
            drain(d);
            ser_in[d] = 1'($urandom_range(0, 1));
         end
      end
      drain(d);
   endtask

   initial begin
      int s_done;
      int s_busy;
      int ok;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         in_valid[d] = 1'b0; in_data[d] = 4'b0000; in_dir[d] = 1'b0; ser_in[d] = 1'b0;
      end
      repeat (4) step();
      rst = 1'b0;
      step();

      ser_in[0] = 1'b1;
      s_done = done_cnt[0];
      send(0, 4'b1011, 1'b0);
      drain(0);
      check("s1_mirror", 0, {28'd0, mir[0]}, 32'hF);
      check("s1_done_pulses", 0, done_cnt[0] - s_done, 1);

      ser_in[0] = 1'b0;
      s_busy = busy_cnt[0];
      send(0, 4'b0110, 1'b1);
      drain(0);
      check("s2_mirror", 0, {28'd0, mir[0]}, 32'h0);
      check("s2_busy_cycles", 0, busy_cnt[0] - s_busy, 6);

      s_done = done_cnt[0];
      send(0, 4'b0001, 1'b0);
      send(0, 4'b1110, 1'b1);
      send(0, 4'b0101, 1'b0);
      drain(0);
      check("s3_done_pulses", 0, done_cnt[0] - s_done, 3);

      send(0, 4'b1100, 1'b0);
      send(0, 4'b0011, 1'b1);
      drain(0);
      check("s5_load_spacing", 0, last_load[0] - prev_load[0], 5 + GAP);

      s_done = done_cnt[0];
      send(0, 4'b1001, 1'b0);
      send(0, 4'b0111, 1'b0);
      in_valid[0] = 1'b0;
      ok = 0;
      for (int t = 0; t < 50 && ok == 0; t++) begin
         @(negedge clk);
         if (usr_mode[0] == 2'b01) ok = 1;
         step();
      end
      check("s4_reach_shift", 0, ok, 1);
      rst = 1'b1;
      step();
      @(negedge clk);
      check("s4_rst_mode", 0, {30'd0, usr_mode[0]}, 32'h0);
      check("s4_rst_busy", 0, {31'd0, busy[0]}, 32'h0);
      check("s4_rst_ready", 0, {31'd0, in_ready[0]}, 32'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("s4_ready_after_release", 0, {31'd0, in_ready[0]}, 32'h1);
      repeat (10) step();
      check("s4_no_done", 0, done_cnt[0] - s_done, 0);
      check("s4_fifo_empty", 0, {31'd0, busy[0]}, 32'h0);

      ser_in[1] = 1'b0;
      s_done = done_cnt[1];
      s_busy = busy_cnt[1];
      send(1, 4'b1000, 1'b0);
      drain(1);
      check("s6_mirror", 1, {28'd0, mir[1]}, 32'h4);
      check("s6_done_pulses", 1, done_cnt[1] - s_done, 1);
      check("s6_busy_cycles", 1, busy_cnt[1] - s_busy, 3);

      random_run(0, 40);
      random_run(1, 40);
      check("leftover_words", 0, sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/usr_ctrl.md
USR_CTRL -- requirements
Module: usr_ctrl

Interface
REQ-001 SHALL have parameter SHIFT_LEN, default 4, number of shift cycles issued per word; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream word available.
REQ-005 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port in_data  input  4  parallel word to load downstream.
REQ-007 SHALL have port in_dir  input  1  shift direction for this word: 0 = right (mode 01), 1 = left (mode 10).
REQ-008 SHALL have port ser_in  input  1  serial fill bit driven on usr_inp[0] during shift cycles.
REQ-009 SHALL have port usr_mode  output  2  mode command to the downstream 4-bit universal shift register (00 hold, 01 right, 10 left, 11 load).
REQ-010 SHALL have port usr_inp  output  4  data/serial-bit bus to the downstream shift register.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking the end of a word's shift sequence.

Function
REQ-013 SHALL accept a word, together with its in_dir, on any rising edge where in_valid and in_ready are both high.
REQ-014 SHALL buffer accepted words in a 2-entry FIFO; in_ready = not full and not rst; no push-bypass when full, even if a pop occurs in the same cycle.
REQ-015 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-016 IDLE: usr_mode=00 and usr_inp=0; SHALL go to LOAD on the next edge when the FIFO is non-empty at that edge, including a word pushed at that same edge.
REQ-017 LOAD (1 cycle): usr_mode=11 and usr_inp=FIFO head data; the FIFO head SHALL pop and its dir SHALL latch at the closing edge; next state is SHIFT.
REQ-018 SHIFT: usr_mode=01 when the latched dir is 0, 10 when it is 1; usr_inp={3'b000, ser_in}.
REQ-019 SHIFT SHALL last exactly SHIFT_LEN cycles, counted by a 3-bit counter cleared on LOAD exit; next state is DONE.
REQ-020 DONE (1 cycle): usr_mode=00, usr_inp=0, done=1; next state per REQ-026/027.
REQ-021 usr_mode, usr_inp and done SHALL be combinational decodes of registered state only; they have no path from in_valid, in_data or in_dir.
REQ-022 Latency: a word accepted into an empty FIFO while in IDLE at edge k SHALL show usr_mode=11 in the cycle after edge k, and done in cycle k+SHIFT_LEN+2.
REQ-023 Words SHALL be issued in acceptance order; none are dropped or duplicated.

Reset
REQ-024 While rst is high at a rising edge, the block SHALL clear: state to IDLE, FIFO to empty, shift counter to 0, latched dir to 0.
REQ-025 Reset outputs: usr_mode=00, usr_inp=0, busy=0, done=0; in_ready=0 while rst is high and 1 in the first cycle after release. Reset mid-frame SHALL abort the frame without a done pulse.

Configuration
REQ-026 With USR_CTRL_AUTOCHAIN_EN defined, DONE SHALL go directly to LOAD when the FIFO is non-empty, otherwise to IDLE; back-to-back period is SHIFT_LEN+2 cycles.
REQ-027 Without USR_CTRL_AUTOCHAIN_EN, DONE SHALL always go to IDLE; back-to-back period is SHIFT_LEN+3 cycles.

Verification
REQ-028 Scenario 1: reset, then push in_data=1011, in_dir=0, ser_in=1 -> sequence 11/1011, then 01 x4, then done pulse; mirrored 4-bit register ends at 1111.
REQ-029 Scenario 2: push 0110, in_dir=1, ser_in=0 -> usr_mode 10 for exactly 4 cycles; mirrored register ends at 0000; busy high for 6 cycles.
REQ-030 Scenario 3: push 3 words back-to-back while in_valid is held high -> in_ready drops after 2 are buffered; all 3 are issued in order; done pulses exactly 3 times.
REQ-031 Scenario 4: assert rst during the 2nd SHIFT cycle -> next cycle usr_mode=00, busy=0, in_ready=0; no done pulse; FIFO is empty afterwards.
REQ-032 Scenario 5: two queued words with SHIFT_LEN=4 -> LOAD-to-LOAD spacing is 6 cycles with USR_CTRL_AUTOCHAIN_EN defined and 7 cycles without it.
REQ-033 Scenario 6: SHIFT_LEN=1, push 1000, in_dir=0 -> exactly one usr_mode=01 cycle, then done.
